// File: rtl/reset_button_hold_detect.sv
// Front-panel reset-button front end: a 2-FF synchroniser, a debouncer and a hold timer.
// A press held long enough gives one fixed-width active-low reset pulse.
// A press released earlier gives a one-cycle short-press strobe.
// FM_PS_EN is compared with `PwrSW_On. A board-level define can override it before this file.

`ifndef PwrSW_On
`define PwrSW_On 1'b1
`endif

module reset_button_hold_detect #(
    parameter int DEBOUNCE_CNT = 1024,
    parameter int HOLD_CNT     = 131072,
    parameter int PULSE_CNT    = 3277
) (
    input  logic CLK32KHz,
    input  logic ResetI,
    input  logic RstBtnN_i,
    input  logic FM_PS_EN,
    output logic ResetOut_ox,
    output logic BtnPressed_o,
    output logic ShortPress_o,
    output logic HoldActive_o
);

    localparam int DB_W    = $clog2(DEBOUNCE_CNT) + 1;
    localparam int HOLD_W  = $clog2(HOLD_CNT) + 1;
    localparam int PULSE_W = $clog2(PULSE_CNT) + 1;

    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CNT - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CNT - 1);
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(PULSE_CNT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        ASSERT   = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    logic               sync_meta;
    logic               sync_n;
    logic [DB_W-1:0]    db_cnt;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [PULSE_W-1:0] pulse_cnt;
    logic               need_release;
    logic               power_on;
    state_t             state;

    assign power_on = (FM_PS_EN == `PwrSW_On);

    // Two-stage synchroniser for the raw button. It resets to the released level.
    always_ff @(posedge CLK32KHz or posedge ResetI) begin
        if (ResetI) begin
            sync_meta <= 1'b1;
            sync_n    <= 1'b1;
        end else begin
            sync_meta <= RstBtnN_i;
            sync_n    <= sync_meta;
        end
    end

    // Debouncer: the level must differ from the accepted level for DEBOUNCE_CNT straight ticks.
    always_ff @(posedge CLK32KHz or posedge ResetI) begin
        if (ResetI) begin
            db_cnt       <= '0;
            BtnPressed_o <= 1'b0;
        end else if (~sync_n == BtnPressed_o) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            BtnPressed_o <= ~sync_n;
            db_cnt       <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    // Hold-timer FSM with registered outputs.
    // When transitions coincide, power-off wins over release, and release wins over hold expiry.
    always_ff @(posedge CLK32KHz or posedge ResetI) begin
        if (ResetI) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            pulse_cnt    <= '0;
            need_release <= 1'b0;
            ResetOut_ox  <= 1'b1;
            ShortPress_o <= 1'b0;
            HoldActive_o <= 1'b0;
        end else begin
            ShortPress_o <= 1'b0;
            if (!power_on) begin
                // A button still pressed across a power cycle must be released before it can re-arm.
                state        <= IDLE;
                hold_cnt     <= '0;
                pulse_cnt    <= '0;
                need_release <= BtnPressed_o;
                ResetOut_ox  <= 1'b1;
                HoldActive_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        ResetOut_ox  <= 1'b1;
                        HoldActive_o <= 1'b0;
                        if (!BtnPressed_o) begin
                            need_release <= 1'b0;
                        end else if (!need_release) begin
                            state        <= HOLD;
                            hold_cnt     <= '0;
                            HoldActive_o <= 1'b1;
                        end
                    end
                    HOLD: begin
                        if (!BtnPressed_o) begin
                            state        <= IDLE;
                            hold_cnt     <= '0;
                            ShortPress_o <= 1'b1;
                            HoldActive_o <= 1'b0;
                        end else if (hold_cnt == HOLD_LAST) begin
                            state        <= ASSERT;
                            hold_cnt     <= '0;
                            pulse_cnt    <= '0;
                            ResetOut_ox  <= 1'b0;
                            HoldActive_o <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                    ASSERT: begin
                        // The pulse always runs to full width, even if the button is released.
                        if (pulse_cnt == PULSE_LAST) begin
                            state       <= WAIT_REL;
                            pulse_cnt   <= '0;
                            ResetOut_ox <= 1'b1;
                        end else begin
                            pulse_cnt <= pulse_cnt + PULSE_W'(1);
                        end
                    end
                    WAIT_REL: begin
                        ResetOut_ox <= 1'b1;
                        if (!BtnPressed_o) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reset_button_hold_detect.sv
// Directed testbench for reset_button_hold_detect with short timing parameters.
// Every tick is checked against hand-derived windows. Tick k is the value sampled 1 ns after the k-th rising edge following the press.

`ifndef PwrSW_On
`define PwrSW_On 1'b1
`endif

module tb_reset_button_hold_detect;

    localparam int DB = 4;
    localparam int HC = 20;
    localparam int PC = 5;

    logic clk = 1'b0;
    logic rst;
    logic btn_n;
    logic ps_en;
    logic reset_out;
    logic btn_pressed;
    logic short_press;
    logic hold_active;

    int tests_run = 0;
    int tests_failed = 0;

    reset_button_hold_detect #(
        .DEBOUNCE_CNT(DB),
        .HOLD_CNT    (HC),
        .PULSE_CNT   (PC)
    ) dut (
        .CLK32KHz    (clk),
        .ResetI      (rst),
        .RstBtnN_i   (btn_n),
        .FM_PS_EN    (ps_en),
        .ResetOut_ox (reset_out),
        .BtnPressed_o(btn_pressed),
        .ShortPress_o(short_press),
        .HoldActive_o(hold_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s = %0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Press at tick 0, and release the raw input after tick raw_end is sampled.
    // Each output is expected high only inside its window [lo..hi]; use lo > hi for "never".
    task automatic run(input string tag, input int n, input int raw_end,
                       input int btn_lo, input int btn_hi,
                       input int hold_lo, input int hold_hi,
                       input int rst_lo, input int rst_hi,
                       input int short_at);
        btn_n = 1'b0;
        for (int k = 1; k <= n; k++) begin
            step();
            check($sformatf("%s btn k=%0d", tag, k), btn_pressed, (k >= btn_lo && k <= btn_hi));
            check($sformatf("%s hold k=%0d", tag, k), hold_active, (k >= hold_lo && k <= hold_hi));
            check($sformatf("%s rstout k=%0d", tag, k), reset_out, !(k >= rst_lo && k <= rst_hi));
            check($sformatf("%s short k=%0d", tag, k), short_press, (k == short_at));
            if (k == raw_end) btn_n = 1'b1;
        end
    endtask

    initial begin
        rst   = 1'b1;
        btn_n = 1'b1;
        ps_en = `PwrSW_On;
        #2;
        check("reset rstout", reset_out, 1);
        check("reset btn", btn_pressed, 0);
        check("reset short", short_press, 0);
        check("reset hold", hold_active, 0);
        #20;
        rst = 1'b0;
        repeat (3) step();

        // 1: long hold fires one pulse over ticks 27..31, and a re-press fires again.
        run("s1", 50, 40, 6, 45, 7, 26, 27, 31, -1);
        run("s1b", 50, 40, 6, 45, 7, 26, 27, 31, -1);

        // 2: short press gives a strobe one tick after the debounced release.
        run("s2", 25, 10, 6, 15, 7, 16, 1, 0, 17);

        // 3: glitches 3 ticks wide never pass the debouncer.
        btn_n = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            step();
            check($sformatf("s3 btn k=%0d", k), btn_pressed, 0);
            check($sformatf("s3 hold k=%0d", k), hold_active, 0);
            btn_n = ((k / 3) % 2 == 0) ? 1'b0 : 1'b1;
        end
        btn_n = 1'b1;
        repeat (10) step();

        // 4: power drops at tick 15 of the hold. The held button must not fire until it is released and pressed again.
        btn_n = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step();
            check($sformatf("s4 hold k=%0d", k), hold_active, (k >= 7 && k <= 15));
            check($sformatf("s4 rstout k=%0d", k), reset_out, 1);
            check($sformatf("s4 short k=%0d", k), short_press, 0);
            if (k == 15) ps_en = ~`PwrSW_On;
        end
        ps_en = `PwrSW_On;
        for (int k = 1; k <= 30; k++) begin
            step();
            check($sformatf("s4on hold k=%0d", k), hold_active, 0);
            check($sformatf("s4on rstout k=%0d", k), reset_out, 1);
        end
        btn_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("s4rel btn k=%0d", k), btn_pressed, (k < 6));
            check($sformatf("s4rel short k=%0d", k), short_press, 0);
        end
        run("s4re", 50, 40, 6, 45, 7, 26, 27, 31, -1);

        // 5: async reset during the 2nd low cycle of the pulse, then re-arm from IDLE.
        btn_n = 1'b0;
        repeat (28) step();
        check("s5 pulse low", reset_out, 0);
        #2 rst = 1'b1;
        #1;
        check("s5 async rstout", reset_out, 1);
        check("s5 async btn", btn_pressed, 0);
        check("s5 async hold", hold_active, 0);
        @(negedge clk);
        rst = 1'b0;
        run("s5re", 50, 40, 6, 45, 7, 26, 27, 31, -1);

        // 6: release lands on the same edge as hold expiry, so the release wins.
        run("s6", 35, 20, 6, 25, 7, 26, 1, 0, 27);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
